// File: rtl/cpu_pkg.sv
// Shared control-unit types: fetch FSM encoding, bus width defaults, PC source priority.
// Pure declarations, no logic, no latency, no backpressure.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    // Higher value wins when several PC updates are requested together.
    typedef enum logic [1:0] {
        PC_SRC_HOLD = 2'd0,
        PC_SRC_INC  = 2'd1,
        PC_SRC_LOAD = 2'd2
    } pc_src_e;

    function automatic pc_src_e pc_src_sel(input logic load, input logic inc);
        if (load)
            return PC_SRC_LOAD;
        else if (inc)
            return PC_SRC_INC;
        else
            return PC_SRC_HOLD;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: control-unit requests, RAM read port and IR/PC status.
// Wires only; no latency; RAM side is valid-only, with no ready.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              fetch;
    logic              pc_inc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_value;
    logic [DATA_W-1:0] ram_data;
    logic              ram_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [DATA_W-1:0] instruction;
    logic              ir_valid;
    logic              busy;
    logic [ADDR_W-1:0] pc;
    logic              fault;

    modport master (
        output fetch, pc_inc, pc_load, pc_load_value, ram_data, ram_valid,
        input  ram_addr, ram_rd, instruction, ir_valid, busy, pc, fault
    );

    modport slave (
        input  fetch, pc_inc, pc_load, pc_load_value, ram_data, ram_valid,
        output ram_addr, ram_rd, instruction, ir_valid, busy, pc, fault
    );
endinterface

// File: rtl/pc_register.sv
// Program counter register with load and modulo-2^ADDR_W increment.
// Updates one cycle after the request; load beats inc; never stalls.
module pc_register #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= '0;
        else if (load)
            pc <= load_value;
        else if (inc)
            pc <= pc + ADDR_W'(1);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns PC and IR, reads RAM at PC, then post-increments PC.
// Latency is 3 cycles from FETCH to IR_VALID, plus RAM wait cycles; it abandons the read after TIMEOUT WAIT cycles.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.slave   bus
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    fetch_state_e      state;
    logic [7:0]        wait_cnt;
    logic [7:0]        wait_cnt_nxt;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              ram_rd;
    logic              busy;
    logic              fault;
    logic [ADDR_W-1:0] pc;
    logic              inc_req;
    pc_src_e           pc_src;

    // The post-increment happens on RAM_VALID in WAIT. An operand skip happens only in IDLE, when no fetch is requested.
    assign inc_req      = ((state == IDLE) && bus.pc_inc && !bus.fetch) ||
                          ((state == WAIT) && bus.ram_valid);
    assign pc_src       = pc_src_sel(bus.pc_load, inc_req);
    assign wait_cnt_nxt = wait_cnt + 8'd1;

    pc_register #(.ADDR_W(ADDR_W)) u_pc_register (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pc_src == PC_SRC_LOAD),
        .load_value (bus.pc_load_value),
        .inc        (pc_src == PC_SRC_INC),
        .pc         (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            ram_rd   <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            if (bus.pc_load) begin
                // A jump aborts any fetch in flight and discards a response in the same cycle.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.fetch) begin
                            state    <= REQ;
                            ir_valid <= 1'b0;
                            ram_rd   <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    REQ: begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (bus.ram_valid) begin
                            ir       <= bus.ram_data;
                            ir_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt_nxt;
                            if (wait_cnt_nxt == TIMEOUT_C) begin
                                fault <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ram_addr    = pc;
    assign bus.pc          = pc;
    assign bus.ram_rd      = ram_rd;
    assign bus.instruction = ir;
    assign bus.ir_valid    = ir_valid;
    assign bus.busy        = busy;
    assign bus.fault       = fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of the fetch unit against a transaction-level PC/IR model.
// A RAM responder answers each read strobe after a chosen number of cycles, or never.
module tb_instruction_fetch_unit;

    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    instruction_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    instruction_fetch_unit #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int         resp_delay = -1;

    logic [7:0] m_pc;
    logic [7:0] m_ir;
    logic       m_irv;
    logic       m_fault;

    // The RAM answers d cycles after the cycle in which it sees RAM_RD. A delay of -1 means no answer.
    initial begin
        int         k;
        logic [7:0] a;
        k = 0;
        a = '0;
        bus.ram_valid = 1'b0;
        bus.ram_data  = '0;
        forever begin
            @(negedge clk);
            bus.ram_valid = 1'b0;
            if (!rst_n) begin
                k = 0;
            end else begin
                if (k > 0) begin
                    k = k - 1;
                    if (k == 0) begin
                        bus.ram_valid = 1'b1;
                        bus.ram_data  = mem[a];
                    end
                end
                if (bus.ram_rd && resp_delay >= 0) begin
                    k = resp_delay + 1;
                    a = bus.ram_addr;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"},    32'(bus.pc),          32'(m_pc));
        check({tag, "_ir"},    32'(bus.instruction), 32'(m_ir));
        check({tag, "_irv"},   32'(bus.ir_valid),    32'(m_irv));
        check({tag, "_fault"}, 32'(bus.fault),       32'(m_fault));
    endtask

    task automatic load_pc(input logic [7:0] v);
        bus.pc_load       = 1'b1;
        bus.pc_load_value = v;
        @(negedge clk);
        bus.pc_load = 1'b0;
        m_pc = v;
        check("load_pc", 32'(bus.pc), 32'(m_pc));
    endtask

    task automatic inc_pc();
        bus.pc_inc = 1'b1;
        @(negedge clk);
        bus.pc_inc = 1'b0;
        m_pc = 8'((int'(m_pc) + 1) % 256);
        check("inc_pc", 32'(bus.pc), 32'(m_pc));
    endtask

    // Called and returning at a falling edge. The model expects success when the RAM answers within TIMEOUT WAIT cycles.
    task automatic do_fetch(input int d, input bit with_inc, input bit inc_in_wait, input string tag);
        int cyc;
        bit ok;
        ok = (d >= 0) && (d < TO);
        resp_delay = ok ? d : -1;
        bus.fetch  = 1'b1;
        bus.pc_inc = with_inc;
        @(negedge clk);
        bus.fetch  = 1'b0;
        bus.pc_inc = 1'b0;
        check({tag, "_rd"},   32'(bus.ram_rd),   32'd1);
        check({tag, "_addr"}, 32'(bus.ram_addr), 32'(m_pc));
        cyc = 0;
        for (int i = 0; i < 60 && bus.busy; i++) begin
            cyc++;
            bus.pc_inc = inc_in_wait && (i == 1);
            @(negedge clk);
        end
        bus.pc_inc = 1'b0;
        if (ok) begin
            m_ir  = mem[m_pc];
            m_pc  = 8'((int'(m_pc) + 1) % 256);
            m_irv = 1'b1;
        end else begin
            m_fault = 1'b1;
            m_irv   = 1'b0;
        end
        check({tag, "_busy_cycles"}, 32'(cyc), ok ? 32'(2 + d) : 32'(1 + TO));
        check_state(tag);
    endtask

    initial begin
        logic [7:0] prev_ir;
        rst_n             = 1'b0;
        bus.fetch         = 1'b0;
        bus.pc_inc        = 1'b0;
        bus.pc_load       = 1'b0;
        bus.pc_load_value = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[8'h00] = 8'h06;
        mem[8'hFF] = 8'h20;
        m_pc = '0; m_ir = '0; m_irv = 1'b0; m_fault = 1'b0;

        #12;
        check_state("reset");
        check("reset_rd",   32'(bus.ram_rd), 32'd0);
        check("reset_busy", 32'(bus.busy),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic fetch with cycle-exact timing
        resp_delay = 0;
        bus.fetch = 1'b1;
        @(negedge clk);
        bus.fetch = 1'b0;
        check("basic_rd_c1",   32'(bus.ram_rd),   32'd1);
        check("basic_addr_c1", 32'(bus.ram_addr), 32'h00);
        check("basic_busy_c1", 32'(bus.busy),     32'd1);
        @(negedge clk);
        check("basic_rd_c2",   32'(bus.ram_rd),   32'd0);
        check("basic_busy_c2", 32'(bus.busy),     32'd1);
        check("basic_irv_c2",  32'(bus.ir_valid), 32'd0);
        @(negedge clk);
        check("basic_ir_c3",   32'(bus.instruction), 32'h06);
        check("basic_irv_c3",  32'(bus.ir_valid),    32'd1);
        check("basic_pc_c3",   32'(bus.pc),          32'h01);
        check("basic_busy_c3", 32'(bus.busy),        32'd0);
        m_pc = 8'h01; m_ir = 8'h06; m_irv = 1'b1;

        // Wrap on fetch post-increment
        load_pc(8'hFF);
        do_fetch(0, 1'b0, 1'b0, "wrap");
        check("wrap_ir_const", 32'(bus.instruction), 32'h20);

        // Wrap on PC_INC
        load_pc(8'hFF);
        inc_pc();

        // Timeout, then a successful fetch with FAULT still set
        load_pc(8'h30);
        do_fetch(-1, 1'b0, 1'b0, "timeout");
        do_fetch(1, 1'b0, 1'b0, "after_fault");

        // A jump that coincides with RAM_VALID discards the response
        load_pc(8'h10);
        prev_ir    = m_ir;
        resp_delay = 0;
        bus.fetch  = 1'b1;
        @(negedge clk);
        bus.fetch = 1'b0;
        @(negedge clk);
        bus.pc_load       = 1'b1;
        bus.pc_load_value = 8'h40;
        @(negedge clk);
        bus.pc_load = 1'b0;
        m_pc = 8'h40; m_irv = 1'b0;
        check("abort_ir",   32'(bus.instruction), 32'(prev_ir));
        check("abort_busy", 32'(bus.busy),        32'd0);
        check_state("abort");

        // PC_LOAD together with FETCH in IDLE: the load wins and no read starts
        bus.fetch         = 1'b1;
        bus.pc_load       = 1'b1;
        bus.pc_load_value = 8'h55;
        @(negedge clk);
        bus.fetch   = 1'b0;
        bus.pc_load = 1'b0;
        m_pc = 8'h55;
        check("load_fetch_busy", 32'(bus.busy),   32'd0);
        check("load_fetch_rd",   32'(bus.ram_rd), 32'd0);
        check("load_fetch_pc",   32'(bus.pc),     32'(m_pc));

        // Increment rules
        load_pc(8'h05);
        inc_pc();
        do_fetch(2, 1'b1, 1'b1, "fetch_inc");
        check("fetch_inc_pc_const", 32'(bus.pc), 32'h07);

        // Randomized sequences of jumps, skips and fetches
        for (int n = 0; n < 12; n++) begin
            int skips;
            load_pc(8'($urandom_range(0, 255)));
            skips = $urandom_range(0, 2);
            for (int s = 0; s < skips; s++) inc_pc();
            do_fetch($urandom_range(0, TO + 1), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), "rand");
        end

        // Asynchronous reset in the middle of WAIT
        resp_delay = -1;
        bus.fetch  = 1'b1;
        @(negedge clk);
        bus.fetch = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        m_pc = '0; m_ir = '0; m_irv = 1'b0; m_fault = 1'b0;
        check("areset_rd",   32'(bus.ram_rd), 32'd0);
        check("areset_busy", 32'(bus.busy),   32'd0);
        check_state("areset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_fetch(0, 1'b0, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
